// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader: byte-stream boot loader feeding the cpu external imem/dmem ports.
// Assembles LSB-first 32-bit words, decodes load/run/halt headers, issues one-cycle
// memory write pulses and owns the cpu enable.
// Optional trailer checksum after each non-empty load: define BOOT_LOADER_CHECKSUM_EN.
module cpu_boot_loader #(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [31:0] imem_addr,
  output logic        imem_wen,
  output logic [31:0] imem_wdata,
  output logic [31:0] dmem_addr,
  output logic        dmem_wen,
  output logic [31:0] dmem_wdata,
  output logic        cpu_enable,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_WRITE   = 2'd2
`ifdef BOOT_LOADER_CHECKSUM_EN
    , S_CHK   = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] a_q, a_d;
  logic [13:0] r_q, r_d;
  logic        tgt_q, tgt_d;
  logic        en_d, err_d, busy_d, s_ready_d;
  logic        imem_wen_d, dmem_wen_d;
  logic [31:0] imem_addr_d, imem_wdata_d, dmem_addr_d, dmem_wdata_d;
  logic [31:0] sum_q, sum_d;

  logic        hs;
  logic        last_byte;
  logic [31:0] full_word;
  logic [31:0] wr_addr;

  assign hs        = s_valid & s_ready;
  assign last_byte = hs && (cnt_q == 2'd3);
  assign full_word = {s_data, word_q};
  assign wr_addr   = {14'd0, a_q, 2'b00};

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    r_d          = r_q;
    tgt_d        = tgt_q;
    en_d         = cpu_enable;
    err_d        = err;
    sum_d        = sum_q;
    imem_wen_d   = 1'b0;
    dmem_wen_d   = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    dmem_addr_d  = dmem_addr;
    dmem_wdata_d = dmem_wdata;

    if (hs) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = {s_data, word_q[23:8]};
    end

    case (state_q)
      S_IDLE: begin
        if (last_byte) begin
          case (full_word[31:30])
            2'b00, 2'b01: begin
              en_d  = 1'b0;
              sum_d = 32'd0;
              if (full_word[29:16] != 14'd0) begin
                state_d = S_PAYLOAD;
                a_d     = full_word[15:0];
                r_d     = full_word[29:16];
                tgt_d   = full_word[30];
              end
            end
            2'b10:   if (!err) en_d = 1'b1;
            default: en_d = 1'b0;
          endcase
        end
      end
      S_PAYLOAD: begin
        if (last_byte) begin
          state_d = S_WRITE;
          sum_d   = sum_q + full_word;
          if (tgt_q) begin
            if (32'(a_q) < 32'(DMEM_WORDS)) begin
              dmem_wen_d   = 1'b1;
              dmem_addr_d  = wr_addr;
              dmem_wdata_d = full_word;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (32'(a_q) < 32'(IMEM_WORDS)) begin
              imem_wen_d   = 1'b1;
              imem_addr_d  = wr_addr;
              imem_wdata_d = full_word;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      S_WRITE: begin
        a_d = a_q + 16'd1;
        r_d = r_q - 14'd1;
        if (r_q == 14'd1) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_PAYLOAD;
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (last_byte) begin
          if (full_word != sum_q) err_d = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    s_ready_d = (state_d != S_WRITE);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      r_q        <= '0;
      tgt_q      <= 1'b0;
      sum_q      <= '0;
      s_ready    <= 1'b1;
      busy       <= 1'b0;
      err        <= 1'b0;
      cpu_enable <= 1'b0;
      imem_wen   <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_wen   <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      r_q        <= r_d;
      tgt_q      <= tgt_d;
      sum_q      <= sum_d;
      s_ready    <= s_ready_d;
      busy       <= busy_d;
      err        <= err_d;
      cpu_enable <= en_d;
      imem_wen   <= imem_wen_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      dmem_wen   <= dmem_wen_d;
      dmem_addr  <= dmem_addr_d;
      dmem_wdata <= dmem_wdata_d;
    end
  end

endmodule

// File: doc/cpu_boot_loader.md
Name: cpu_boot_loader

Overview:
- Upstream feeder for the pipelined cpu top. Receives a byte stream over valid/ready from the host link.
- Assembles bytes into 32-bit words and decodes command headers from them.
- Drives the cpu external instruction-memory port (addr_ext/wen_ext/wdata_ext) and data-memory port (addr_ext_2/wen_ext_2/wdata_ext_2).
- Owns the cpu enable: programs are loaded with the core stalled, then released.

Parameters:
- IMEM_WORDS, 512, instruction memory depth in words; writes at or above it are suppressed.
- DMEM_WORDS, 1024, data memory depth in words; writes at or above it are suppressed.

Ports:
- clk  in  1  main clock
- rst  in  1  reset; synchronous, active-high
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_ready  out  1  byte accepted when s_valid & s_ready
- imem_addr  out  32  byte address to cpu addr_ext
- imem_wen  out  1  to cpu wen_ext
- imem_wdata  out  32  to cpu wdata_ext
- dmem_addr  out  32  byte address to cpu addr_ext_2
- dmem_wen  out  1  to cpu wen_ext_2
- dmem_wdata  out  32  to cpu wdata_ext_2
- cpu_enable  out  1  to cpu enable
- busy  out  1  high outside IDLE
- err  out  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset state: all outputs 0 except s_ready=1. Partial word, byte counter and state are cleared. Reset mid-load discards the partial word; no write is issued.
- Word assembly:
  - Bytes are packed LSB-first: byte 0 goes to [7:0], byte 3 to [31:24].
  - A 2-bit byte counter wraps 3→0 on completion.
- Header word fields:
  - [31:30] op: 00 = load imem, 01 = load dmem, 10 = run, 11 = halt.
  - [29:16] N, the word count.
  - [15:0] S, the start word address.
- States:
  - IDLE: collecting header bytes.
  - PAYLOAD: collecting data bytes.
  - WRITE: one cycle, s_ready=0.
  - CHK: only with the optional feature.
- Transitions and actions:
  - IDLE, header complete, op = load, N>0: cpu_enable←0 on the same edge; go to PAYLOAD; internal word address A←S; remaining count R←N.
  - IDLE, op = load, N=0: cpu_enable←0; stay in IDLE; no writes.
  - IDLE, op = run: cpu_enable←1 unless err=1 (with err=1 the command is ignored). Stay in IDLE.
  - IDLE, op = halt: cpu_enable←0. Stay in IDLE.
  - PAYLOAD, 4th byte accepted: go to WRITE.
  - WRITE:
    - Targeted wen is high for exactly this cycle; addr = {14'b0, A, 2'b00}; wdata = assembled word.
    - Then A←A+1 (16-bit wrap, 0xFFFF→0x0000) and R←R−1.
    - R reaching 0 → IDLE (or CHK); otherwise → PAYLOAD.
- Write qualification and output hold:
  - If A ≥ IMEM_WORDS (imem) or A ≥ DMEM_WORDS (dmem), wen stays 0 and err←1. The word is still consumed and the counters still advance.
  - addr/wdata hold their last values when wen=0. The non-target port's wen stays 0.
- Throughput: maximum 5 cycles per payload word (4 byte cycles + 1 WRITE). Latency from the 4th-byte handshake to the wen pulse is 1 cycle.
- cpu_enable is sticky: it changes only on run/halt/load headers or rst.
- err is sticky until rst.
- busy=1 in PAYLOAD, WRITE and CHK.
- s_ready=1 in all states except WRITE. Bytes presented while s_ready=0 are not consumed.

Optional Feature:
- Macro: BOOT_LOADER_CHECKSUM_EN.
- Defined:
  - Each load with N>0 is followed by one trailer word, collected in CHK.
  - The trailer must equal the mod-2^32 sum of the N payload words, including suppressed ones.
  - Mismatch → err←1. Then → IDLE.
  - The accumulator clears on each load header.
- Undefined: no CHK state and no trailer; err is set only by out-of-range writes.

Test Plan:
- rst high 2 cycles, then low → s_ready=1, cpu_enable=0, busy=0, err=0, both wen=0.
- Header 0x00020010 (imem, N=2, S=16), payload 0x11223344 then 0xAABBCCDD → imem_wen pulses twice: addr 0x40 data 0x11223344, addr 0x44 data 0xAABBCCDD; dmem_wen never high.
- Header 0x80000000 (run) → cpu_enable=1 the cycle after the 4th byte. Header 0x40010005 (dmem, N=1, S=5) → cpu_enable=0 at that header. Word 0xDEADBEEF → dmem_wen at addr 0x14.
- Header 0x00010200 (imem, S=512 with IMEM_WORDS=512), one payload word → no imem_wen, err=1. A later run header leaves cpu_enable=0.
- s_valid toggled every other cycle during a 3-word load; rst asserted after the 2nd byte of word 2 → exactly 1 imem write, state IDLE, partial byte discarded.
- BOOT_LOADER_CHECKSUM_EN defined: imem load N=2 of 1 and 2, trailer 3 → err=0; trailer 4 → err=1.
